conv_window_ctrl: RTL and testbench

- Frame sequencer for the 3x3 sliding-window datapath.
- On a start pulse it reads one IMG_W x IMG_H frame from a synchronous image memory in raster order, feeds pixels into the window generator, and tracks which pixels complete a 3x3 window.
- It presents each completed window to the downstream convolution stage with a valid/ready handshake and stalls the pixel stream under backpressure.
- It sits between the image memory, sliding_3x3window and the conv MAC array.

---
 rtl/conv_window_ctrl.sv | 127 ++++++++++++
 tb/tb_conv_window_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
// Frame sequencer for the 3x3 sliding-window datapath: streams one frame from image
// memory into the window generator and hands completed windows to the conv stage.
module conv_window_ctrl #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iStart,
    output logic              oMemRd,
    output logic [ADDR_W-1:0] oMemAddr,
    input  logic [PIX_W-1:0]  iMemData,
    output logic              oWinRsn,
    output logic [PIX_W-1:0]  oPixel,
    output logic              oPixelValid,
    output logic              oWinValid,
    input  logic              iConvReady,
    output logic [4:0]        oWinRow,
    output logic [4:0]        oWinCol,
    output logic              oBusy,
    output logic              oDone
);

    localparam int NPIX = IMG_W * IMG_H;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stateT;

    stateT             rState, sNext;
    logic [ADDR_W-1:0] rAddr;
    logic              rInflight;
    logic [1:0]        rCount;
    logic              rWrPtr, rRdPtr;
    logic [PIX_W-1:0]  rFifo [2];
    logic [4:0]        rCol, rRow;
    logic              rWinClr;

    logic startAcc, handshake, push, fifoWr, fifoRd, qualify, lastWin;

    assign startAcc  = (rState == IDLE) && iStart;
    assign handshake = oWinValid && iConvReady;

    // Returning read data bypasses an empty FIFO so the stream sustains 1 pixel/clock.
    assign oPixelValid = ((rCount != 2'd0) || rInflight) && !(oWinValid && !iConvReady);
    assign push        = oPixelValid;
    assign oPixel      = (rCount != 2'd0) ? rFifo[rRdPtr] : (rInflight ? iMemData : '0);
    assign fifoRd      = push && (rCount != 2'd0);
    assign fifoWr      = rInflight && !(push && (rCount == 2'd0));

    assign oMemRd   = (rState == RUN) && (({1'b0, rCount} + {2'b0, rInflight}) < 3'd2);
    assign oMemAddr = rAddr;

    assign qualify = (rRow >= 5'd2) && (rCol >= 5'd2);
    assign lastWin = handshake && (oWinRow == 5'(IMG_H - 3)) && (oWinCol == 5'(IMG_W - 3));

    assign oWinRsn = !rWinClr;
    assign oBusy   = (rState == RUN) || (rState == DRAIN);
    assign oDone   = (rState == DONE);

    always_comb begin
        // NOTE: default assigned first so every path drives sNext and no latch is inferred.
        sNext = rState;
        unique case (rState)
            IDLE:  if (iStart) sNext = RUN;
            RUN:   if (oMemRd && (rAddr == ADDR_W'(NPIX - 1))) sNext = DRAIN;
            DRAIN: if (lastWin) sNext = DONE;
            DONE:  sNext = IDLE;
            default: sNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            rState    <= IDLE;
            rAddr     <= '0;
            rInflight <= 1'b0;
            rCount    <= 2'd0;
            rWrPtr    <= 1'b0;
            rRdPtr    <= 1'b0;
            rCol      <= 5'd0;
            rRow      <= 5'd0;
            rWinClr   <= 1'b0;
            oWinValid <= 1'b0;
            oWinRow   <= 5'd0;
            oWinCol   <= 5'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rState    <= sNext;
            rWinClr   <= startAcc;
            rInflight <= oMemRd;
            rCount    <= rCount + {1'b0, fifoWr} - {1'b0, fifoRd};
            if (fifoWr) rWrPtr <= ~rWrPtr;
            if (fifoRd) rRdPtr <= ~rRdPtr;

            if (startAcc)    rAddr <= '0;
            else if (oMemRd) rAddr <= rAddr + 1'b1;

            if (startAcc) begin
                rCol <= 5'd0;
                rRow <= 5'd0;
            end else if (push) begin
                if (rCol == 5'(IMG_W - 1)) begin
                    rCol <= 5'd0;
                    rRow <= rRow + 5'd1;
                end else begin
                    rCol <= rCol + 5'd1;
                end
            end

            // A qualifying push at a handshake edge keeps the window valid with new coordinates.
            if (push && qualify) begin
                oWinValid <= 1'b1;
                oWinRow   <= rRow - 5'd2;
                oWinCol   <= rCol - 5'd2;
            end else if (handshake) begin
                oWinValid <= 1'b0;
            end
        end
    end

    // NOTE: storage is left unreset; rCount alone defines which entries are meaningful.
    always_ff @(posedge iClk) begin
        if (fifoWr) rFifo[rWrPtr] <= iMemData;
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl: 4x4 scenarios plus one randomised 28x28 frame.
module tb_conv_window_ctrl;

    logic iClk = 1'b0;
    logic iRsn = 1'b0;
    always #5 iClk = ~iClk;

    int nAssert = 0;
    int nFail   = 0;

    // 4x4 instance
    logic       s4Start = 1'b0, s4Ready = 1'b1;
    logic       s4Rd, s4WinRsn, s4PixV, s4WinV, s4Busy, s4Done;
    logic [3:0] s4Addr;
    logic [7:0] s4Data = '0, s4Pix;
    logic [4:0] s4Row, s4Col;

    // 28x28 instance
    logic       s28Start = 1'b0, s28Ready = 1'b1;
    logic       s28Rd, s28WinRsn, s28PixV, s28WinV, s28Busy, s28Done;
    logic [9:0] s28Addr;
    logic [7:0] s28Data = '0, s28Pix;
    logic [4:0] s28Row, s28Col;

    conv_window_ctrl #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ADDR_W(4)) u_dut4 (
        .iClk(iClk), .iRsn(iRsn), .iStart(s4Start), .oMemRd(s4Rd), .oMemAddr(s4Addr),
        .iMemData(s4Data), .oWinRsn(s4WinRsn), .oPixel(s4Pix), .oPixelValid(s4PixV),
        .oWinValid(s4WinV), .iConvReady(s4Ready), .oWinRow(s4Row), .oWinCol(s4Col),
        .oBusy(s4Busy), .oDone(s4Done)
    );

    conv_window_ctrl #(.IMG_W(28), .IMG_H(28), .PIX_W(8), .ADDR_W(10)) u_dut28 (
        .iClk(iClk), .iRsn(iRsn), .iStart(s28Start), .oMemRd(s28Rd), .oMemAddr(s28Addr),
        .iMemData(s28Data), .oWinRsn(s28WinRsn), .oPixel(s28Pix), .oPixelValid(s28PixV),
        .oWinValid(s28WinV), .iConvReady(s28Ready), .oWinRow(s28Row), .oWinCol(s28Col),
        .oBusy(s28Busy), .oDone(s28Done)
    );

    // Synchronous image memories: memory[i] = i (low 8 bits), data one cycle after the read.
    always @(posedge iClk) if (s4Rd)  s4Data  <= 8'(s4Addr);
    always @(posedge iClk) if (s28Rd) s28Data <= 8'(s28Addr);

    task automatic test_reset();
        #2;
        nAssert++; if (s4Rd !== 1'b0)     begin nFail++; $display("FAIL reset_memrd: got %b want 0", s4Rd); end
        nAssert++; if (s4Addr !== 4'd0)   begin nFail++; $display("FAIL reset_addr: got %0d want 0", s4Addr); end
        nAssert++; if (s4WinRsn !== 1'b1) begin nFail++; $display("FAIL reset_winrsn: got %b want 1", s4WinRsn); end
        nAssert++; if (s4PixV !== 1'b0)   begin nFail++; $display("FAIL reset_pixvalid: got %b want 0", s4PixV); end
        nAssert++; if (s4WinV !== 1'b0)   begin nFail++; $display("FAIL reset_winvalid: got %b want 0", s4WinV); end
        nAssert++; if ({s4Busy, s4Done} !== 2'b00) begin nFail++; $display("FAIL reset_busydone: got %b want 00", {s4Busy, s4Done}); end
        nAssert++; if ({s28Busy, s28Done, s28WinRsn} !== 3'b001) begin nFail++; $display("FAIL reset_28: got %b want 001", {s28Busy, s28Done, s28WinRsn}); end
        @(posedge iClk); #1 iRsn = 1'b1;
        @(posedge iClk); #1;
    endtask

    // mode 0: ready held high; 1: 5-cycle stall on first window; 2: ready toggles every
    // cycle; 3: iStart re-pulsed mid-frame. Called at posedge+1 with the DUT in IDLE.
    task automatic run_frame4(input int mode, input string tag);
        int c, nextAddr, pi, hsCnt, lastHs, doneCnt, stallLeft, stallReads, firstWin;
        int row, col, exp;
        bit stallUsed, done, hs, mWv;
        int mRow, mCol;
        int expWin[$];
        logic [7:0] expPix[$];
        logic [7:0] ep;
        for (int r = 0; r < 2; r++) for (int k = 0; k < 2; k++) expWin.push_back(r * 32 + k);
        for (int i = 0; i < 16; i++) expPix.push_back(8'(i));
        nextAddr = 0; pi = 0; hsCnt = 0; lastHs = -10; doneCnt = 0; stallLeft = 0;
        stallReads = 0; firstWin = -1; stallUsed = 0; done = 0; mWv = 0; mRow = 0; mCol = 0;

        s4Ready = 1'b1; s4Start = 1'b1;
        @(posedge iClk); #1 s4Start = 1'b0;
        c = 0;
        while (!done && c < 80) begin
            if (mode == 1 && !stallUsed && s4WinV) begin stallUsed = 1; stallLeft = 5; end
            s4Ready = (mode == 2) ? (c % 2 == 1) : (stallLeft == 0);
            s4Start = (mode == 3) && (c == 4 || c == 9);
            @(negedge iClk);
            nAssert++; if (s4WinRsn !== (c != 0)) begin nFail++; $display("FAIL %s winrsn c=%0d: got %b want %b", tag, c, s4WinRsn, c != 0); end
            if (!s4Done) begin
                nAssert++; if (s4Busy !== 1'b1) begin nFail++; $display("FAIL %s busy c=%0d: got %b want 1", tag, c, s4Busy); end
            end
            if (mode == 0 || mode == 3) begin
                nAssert++; if (s4Rd !== (c < 16)) begin nFail++; $display("FAIL %s rd_window c=%0d: got %b want %b", tag, c, s4Rd, c < 16); end
                nAssert++; if (s4PixV !== (c >= 1 && c <= 16)) begin nFail++; $display("FAIL %s pv_window c=%0d: got %b want %b", tag, c, s4PixV, c >= 1 && c <= 16); end
            end
            if (s4Rd) begin
                nAssert++; if (int'(s4Addr) !== nextAddr) begin nFail++; $display("FAIL %s addr c=%0d: got %0d want %0d", tag, c, s4Addr, nextAddr); end
                nextAddr++;
                if (stallLeft > 0) stallReads++;
            end
            nAssert++; if (s4WinV !== mWv) begin nFail++; $display("FAIL %s winvalid c=%0d: got %b want %b", tag, c, s4WinV, mWv); end
            if (stallLeft > 0) begin
                nAssert++; if (s4PixV !== 1'b0 || int'(s4Row) !== 0 || int'(s4Col) !== 0)
                    begin nFail++; $display("FAIL %s stall_hold c=%0d: got pv=%b (%0d,%0d) want pv=0 (0,0)", tag, c, s4PixV, s4Row, s4Col); end
            end
            if (s4WinV && firstWin < 0) firstWin = c;
            if (s4PixV) begin
                ep = (expPix.size() > 0) ? expPix.pop_front() : 8'hxx;
                nAssert++; if (s4Pix !== ep) begin nFail++; $display("FAIL %s pixel c=%0d: got %0d want %0d", tag, c, s4Pix, ep); end
            end
            hs = s4WinV && s4Ready;
            if (hs) begin
                exp = (expWin.size() > 0) ? expWin.pop_front() : -1;
                nAssert++; if (int'(s4Row) * 32 + int'(s4Col) !== exp)
                    begin nFail++; $display("FAIL %s window c=%0d: got (%0d,%0d) want code %0d", tag, c, s4Row, s4Col, exp); end
                hsCnt++; lastHs = c;
            end
            if (s4Done) begin
                doneCnt++; done = 1;
                nAssert++; if (c !== lastHs + 1) begin nFail++; $display("FAIL %s done_latency: got cycle %0d want %0d", tag, c, lastHs + 1); end
            end
            // Reference window-valid register driven by the observed push/handshake events.
            row = pi / 4; col = pi % 4;
            if (s4PixV && row >= 2 && col >= 2) begin mWv = 1; mRow = row - 2; mCol = col - 2; end
            else if (hs) mWv = 0;
            if (s4PixV) pi++;
            if (mWv && !hs && s4WinV && (int'(s4Row) !== mRow || int'(s4Col) !== mCol) && !s4PixV) begin
                nAssert++; nFail++; $display("FAIL %s coords c=%0d: got (%0d,%0d) want (%0d,%0d)", tag, c, s4Row, s4Col, mRow, mCol);
            end
            if (stallLeft > 0) stallLeft--;
            @(posedge iClk); #1;
            c++;
        end
        s4Start = 1'b0; s4Ready = 1'b1;
        nAssert++; if (!done) begin nFail++; $display("FAIL %s timeout: got no oDone want oDone within 80 cycles", tag); end
        nAssert++; if ({s4Busy, s4Done} !== 2'b00) begin nFail++; $display("FAIL %s idle_after: got %b want 00", tag, {s4Busy, s4Done}); end
        nAssert++; if (nextAddr !== 16) begin nFail++; $display("FAIL %s read_count: got %0d want 16", tag, nextAddr); end
        nAssert++; if (hsCnt !== 4 || expWin.size() != 0) begin nFail++; $display("FAIL %s windows: got %0d want 4", tag, hsCnt); end
        nAssert++; if (expPix.size() != 0) begin nFail++; $display("FAIL %s pixels_left: got %0d want 0", tag, expPix.size()); end
        nAssert++; if (doneCnt !== 1) begin nFail++; $display("FAIL %s done_count: got %0d want 1", tag, doneCnt); end
        if (mode == 0 || mode == 1 || mode == 3) begin
            nAssert++; if (firstWin !== 12) begin nFail++; $display("FAIL %s first_window: got cycle %0d want 12", tag, firstWin); end
        end
        if (mode == 1) begin
            nAssert++; if (!stallUsed || stallReads > 2) begin nFail++; $display("FAIL %s stall_reads: got %0d want <=2", tag, stallReads); end
        end
    endtask

    task automatic test_nostall();        run_frame4(0, "nostall");   endtask
    task automatic test_backpressure();   run_frame4(1, "stall");     endtask
    task automatic test_ignored_start();  run_frame4(3, "restart");   endtask
    task automatic test_back_to_back();   run_frame4(2, "toggle");    endtask

    task automatic test_midframe_reset();
        bit found;
        found = 0;
        s4Ready = 1'b1; s4Start = 1'b1;
        @(posedge iClk); #1 s4Start = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge iClk);
            if (s4Rd && s4Addr == 4'd7) found = 1;
        end
        nAssert++; if (!found) begin nFail++; $display("FAIL midreset_reach: got no read of 7 want read of 7"); end
        #2 iRsn = 1'b0;
        #1;
        nAssert++; if ({s4Rd, s4Addr, s4PixV, s4WinV, s4Busy, s4Done} !== 9'd0)
            begin nFail++; $display("FAIL midreset_outputs: got %b want 0", {s4Rd, s4Addr, s4PixV, s4WinV, s4Busy, s4Done}); end
        nAssert++; if ({s4WinRsn, s4Pix, s4Row, s4Col} !== {1'b1, 18'd0})
            begin nFail++; $display("FAIL midreset_data: got %b want 1 then zeros", {s4WinRsn, s4Pix, s4Row, s4Col}); end
        @(posedge iClk); #1 iRsn = 1'b1;
        @(posedge iClk); #1;
        run_frame4(0, "after_reset");
    endtask

    task automatic test_full28();
        int c, hsCnt, lastHs, exp;
        bit done;
        int expWin[$];
        logic [7:0] expPix[$];
        logic [7:0] ep;
        for (int r = 0; r < 26; r++) for (int k = 0; k < 26; k++) expWin.push_back(r * 32 + k);
        for (int i = 0; i < 784; i++) expPix.push_back(8'(i));
        hsCnt = 0; lastHs = -10; done = 0;
        s28Start = 1'b1;
        @(posedge iClk); #1 s28Start = 1'b0;
        c = 0;
        while (!done && c < 6000) begin
            s28Ready = 1'($urandom_range(0, 1));
            @(negedge iClk);
            if (s28PixV) begin
                ep = (expPix.size() > 0) ? expPix.pop_front() : 8'hxx;
                nAssert++; if (s28Pix !== ep) begin nFail++; $display("FAIL full28 pixel c=%0d: got %0d want %0d", c, s28Pix, ep); end
            end
            if (s28WinV && s28Ready) begin
                exp = (expWin.size() > 0) ? expWin.pop_front() : -1;
                nAssert++; if (int'(s28Row) * 32 + int'(s28Col) !== exp)
                    begin nFail++; $display("FAIL full28 window c=%0d: got (%0d,%0d) want code %0d", c, s28Row, s28Col, exp); end
                hsCnt++; lastHs = c;
            end
            if (s28Done) begin
                done = 1;
                nAssert++; if (c !== lastHs + 1) begin nFail++; $display("FAIL full28 done_latency: got %0d want %0d", c, lastHs + 1); end
            end
            @(posedge iClk); #1;
            c++;
        end
        s28Ready = 1'b1;
        nAssert++; if (!done) begin nFail++; $display("FAIL full28 timeout: got no oDone want oDone within 6000 cycles"); end
        nAssert++; if (hsCnt !== 676) begin nFail++; $display("FAIL full28 handshakes: got %0d want 676", hsCnt); end
        nAssert++; if (expPix.size() != 0) begin nFail++; $display("FAIL full28 pixels_left: got %0d want 0", expPix.size()); end
    endtask

    initial begin
        test_reset();
        test_nostall();
        test_backpressure();
        test_ignored_start();
        test_back_to_back();
        test_midframe_reset();
        test_full28();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
